// File: rtl/onoff_cmd_gen_pkg.sv
// onoff_cmd_gen_pkg: shared state encoding and counter sizing for onoff_cmd_gen.
//   STATE_W   : width of the FSM state / state_dbg port
//   state_e   : IDLE=0, DEB_PRESS=1, PRESSED=2, LONG_HELD=3, DEB_RELEASE=4
//   cnt_width : bits needed to hold max(a,b) without wrapping
package onoff_cmd_gen_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        PRESSED     = 3'd2,
        LONG_HELD   = 3'd3,
        DEB_RELEASE = 3'd4
    } state_e;
    function automatic int cnt_width(int a, int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction
endpackage

// File: rtl/onoff_cmd_gen_if.sv
// onoff_cmd_gen_if: button-in / command-out bundle of onoff_cmd_gen.
//   btn_raw   : raw push-button level, 1 = pressed
//   j, k      : single-cycle ON / OFF command pulses
//   busy      : FSM not in IDLE
//   state_dbg : current FSM state encoding
//   master drives btn_raw; slave (the generator) drives the rest.
interface onoff_cmd_gen_if;
    import onoff_cmd_gen_pkg::*;
    logic               btn_raw;
    logic               j;
    logic               k;
    logic               busy;
    logic [STATE_W-1:0] state_dbg;
    modport master (output btn_raw, input j, k, busy, state_dbg);
    modport slave  (input btn_raw, output j, k, busy, state_dbg);
endinterface

// File: rtl/onoff_cmd_gen_btn_sync2.sv
// btn_sync2: two-flop synchronizer for an asynchronous level, sync reset to 0.
//   clk, reset : clock and synchronous active-high reset
//   d          : asynchronous input
//   q          : synchronized output, two cycles of latency
module btn_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d, sync_q, sync_d;
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/onoff_cmd_gen.sv
// onoff_cmd_gen: debounced push-button to j (short press) / k (long press) pulse generator.
//   clk, reset : clock and synchronous active-high reset
//   bus        : onoff_cmd_gen_if.slave (btn_raw in; j, k, busy, state_dbg out)
//   Define ONOFF_AUTO_OFF_EN to add an idle timer that issues k AUTO_OFF_CYCLES after j.
module onoff_cmd_gen
    import onoff_cmd_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 64,
    parameter int AUTO_OFF_CYCLES = 256
) (
    input  logic            clk,
    input  logic            reset,
    onoff_cmd_gen_if.slave  bus
);
    localparam int CW = cnt_width(LONG_CYCLES, AUTO_OFF_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          long_q, long_d;
    logic          j_q, j_d, k_q, k_d, busy_q, busy_d;
    logic          btn_sync, long_k, auto_k;

    btn_sync2 u_sync (.clk(clk), .reset(reset), .d(bus.btn_raw), .q(btn_sync));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        long_d  = long_q;
        j_d     = 1'b0;
        long_k  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_sync) state_d = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + CW'(1);
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = DEB_RELEASE;
                    long_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    long_k  = 1'b1;
                end else cnt_d = cnt_q + CW'(1);
            end
            LONG_HELD: begin
                if (!btn_sync) begin
                    state_d = DEB_RELEASE;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            DEB_RELEASE: begin
                // a bounce returns to whichever held state the release came from
                if (btn_sync) begin
                    state_d = long_q ? LONG_HELD : PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    j_d     = !long_q;
                end else cnt_d = cnt_q + CW'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        k_d    = long_k | auto_k;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            long_q  <= 1'b0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            long_q  <= long_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ONOFF_AUTO_OFF_EN
    localparam logic [CW-1:0] AUTO_LAST = CW'(AUTO_OFF_CYCLES - 1);
    logic          armed_q, armed_d;
    logic [CW-1:0] tmr_q, tmr_d;
    // timer runs only while armed and idle; any excursion out of IDLE restarts it
    always_comb begin
        auto_k  = armed_q && state_q == IDLE && tmr_q == AUTO_LAST;
        tmr_d   = (armed_q && state_q == IDLE && !auto_k) ? tmr_q + CW'(1) : '0;
        armed_d = j_d ? 1'b1 : (k_d ? 1'b0 : armed_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q <= 1'b0;
            tmr_q   <= '0;
        end else begin
            armed_q <= armed_d;
            tmr_q   <= tmr_d;
        end
    end
`else
    assign auto_k = 1'b0;
`endif

    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_onoff_cmd_gen.sv
// tb_onoff_cmd_gen: scoreboard bench for onoff_cmd_gen (DEBOUNCE=4, LONG=16, AUTO_OFF=32).
module tb_onoff_cmd_gen;
    import onoff_cmd_gen_pkg::*;
    localparam int D = 4, L = 16, A = 32;
    typedef struct {logic is_k; int at;} ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0, tests = 0, fails = 0;
    ev_t exp_q[$];
    ev_t e;

    onoff_cmd_gen_if bus();
    onoff_cmd_gen #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .AUTO_OFF_CYCLES(A))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every pulse must match the oldest expected event
    always @(negedge clk) begin
        if (bus.j || bus.k) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pulse: unexpected j=%0b k=%0b at cycle %0d, none required", bus.j, bus.k, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.k !== e.is_k || bus.j === bus.k || cyc != e.at) begin
                    fails++;
                    $display("FAIL pulse: got j=%0b k=%0b at cycle %0d, required %s at cycle %0d",
                             bus.j, bus.k, cyc, e.is_k ? "k" : "j", e.at);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic expect_pulse(input logic is_k, input int at);
        ev_t x;
        x.is_k = is_k;
        x.at   = at;
        exp_q.push_back(x);
    endtask

    task automatic expect_j(input int at);
        expect_pulse(1'b0, at);
`ifdef ONOFF_AUTO_OFF_EN
        expect_pulse(1'b1, at + A);
`endif
    endtask

    initial begin
        int c, n;
        bus.btn_raw = 1'b0;
        step(3);
        check("reset j", bus.j, 0);
        check("reset k", bus.k, 0);
        check("reset busy", bus.busy, 0);
        check("reset state", bus.state_dbg, 0);
        reset = 1'b0;
        step(2);
        // short press
        c = cyc;
        bus.btn_raw = 1'b1;
        step(10);
        check("short pressed state", bus.state_dbg, 2);
        bus.btn_raw = 1'b0;
        expect_j(c + 17);
        step(50);
        // glitch
        bus.btn_raw = 1'b1;
        step(2);
        bus.btn_raw = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += int'(bus.busy);
        end
        check("glitch busy cycles", n, 2);
        check("glitch state", bus.state_dbg, 0);
        step(5);
        // long press
        c = cyc;
        bus.btn_raw = 1'b1;
        expect_pulse(1'b1, c + 23);
        step(40);
        check("long held state", bus.state_dbg, 3);
        bus.btn_raw = 1'b0;
        step(40);
        // release bounce
        c = cyc;
        bus.btn_raw = 1'b1;
        step(8);
        bus.btn_raw = 1'b0;
        step(1);
        bus.btn_raw = 1'b1;
        step(1);
        bus.btn_raw = 1'b0;
        expect_j(c + 17);
        step(50);
        // reset mid-PRESSED, button still held
        bus.btn_raw = 1'b1;
        step(10);
        check("pre-reset state", bus.state_dbg, 2);
        reset = 1'b1;
        step(1);
        check("mid reset j", bus.j, 0);
        check("mid reset k", bus.k, 0);
        check("mid reset busy", bus.busy, 0);
        check("mid reset state", bus.state_dbg, 0);
        reset = 1'b0;
        step(4);
        check("re-debounce state", bus.state_dbg, 1);
        step(6);
        check("re-pressed state", bus.state_dbg, 2);
        bus.btn_raw = 1'b0;
        expect_j(cyc + 7);
        step(50);
`ifdef ONOFF_AUTO_OFF_EN
        // auto-off restarted by a glitch press 18 cycles after j
        c = cyc;
        bus.btn_raw = 1'b1;
        step(10);
        bus.btn_raw = 1'b0;
        expect_pulse(1'b0, c + 17);
        step(25);
        c = cyc;
        bus.btn_raw = 1'b1;
        step(2);
        bus.btn_raw = 1'b0;
        expect_pulse(1'b1, c + 37);
        step(50);
`endif
        check("all pulses seen", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
